dbp_buffer_ctrl: RTL and testbench
==================================

// Module: dbp_buffer_ctrl
// PURPOSE
//  Sequencer for the EBPC decoder delta-bit-plane block buffer. Takes a token stream (base, dbp, zero-run)
//  from the bit-plane decoder, expands zero runs into all-zero planes, and counts DATA_W+1 planes per block.
//  Drives the buffer's push/vld/clr and detects malformed token sequences.
//  Sits between the BPC token decoder and the block buffer.
// PARAMETERS
//  DATA_W   8  word width (ebpc_pkg); each block = 1 base + DATA_W+1 dbp planes
//  RUN_W    4  zero-run length field width, taken from tok_data_i[RUN_W-1:0]; RUN_W<=DATA_W
// PORTS
//  clk_i        in   1       clock
//  rst_ni       in   1       reset, asynchronous, active-low
//  clr_i        in   1       synchronous soft clear
//  tok_data_i   in   DATA_W  token payload: base word / MSB-aligned dbp / run length-1
//  tok_kind_i   in   2       00 base, 01 dbp, 10 zero-run, 11 reserved
//  tok_vld_i    in   1       token valid
//  tok_rdy_o    out  1       token accepted when tok_vld_i & tok_rdy_o
//  buf_data_o   out  DATA_W  word to buffer (tok_data_i, or 0 during zero-run)
//  buf_push_o   out  1       push strobe to buffer
//  buf_vld_o    out  1       block complete; high in the cycle of the last (DATA_W+1-th) dbp push
//  buf_rdy_i    in   1       buffer ready; push only legal when high
//  buf_clr_o    out  1       soft clear to buffer (= clr_i, combinational)
//  err_o        out  1       sticky protocol error
//  blk_cnt_o    out  32      completed blocks (stats feature only)
// BEHAVIOUR
//  - Reset: state WAIT_BASE, dbp_cnt=0, run_left=0, err_o=0, blk_cnt_o=0; buf_push_o=buf_vld_o=0.
//  - States: WAIT_BASE -> (base accepted) DBP -> (last plane pushed) WAIT_BASE; DBP <-> ZRUN.
//  - WAIT_BASE/DBP: tok_rdy_o=buf_rdy_i; buf_push_o=tok_vld_i&buf_rdy_i for valid kinds; zero latency.
//  - dbp token in DBP: push tok_data_i, dbp_cnt++; if dbp_cnt==DATA_W: buf_vld_o=1, cnt->0, ->WAIT_BASE.
//  - zero-run token (L=tok_data_i[RUN_W-1:0]+1) in DBP: accepting cycle pushes one zero plane;
//    if L>1 -> ZRUN with run_left=min(L, remaining planes)-1.
//  - ZRUN: tok_rdy_o=0; each buf_rdy_i cycle pushes 0, run_left--, dbp_cnt++; on run_left==0 -> DBP,
//    or -> WAIT_BASE with buf_vld_o=1 if that push was plane DATA_W.
//  - Errors (err_o set next cycle, sticky until clr_i/reset): dbp or zero-run token in WAIT_BASE,
//    base token in DBP, kind 11 -> token consumed, dropped, no push, state unchanged.
//    Zero-run with L > remaining planes -> truncated to remaining, block completes normally.
//  - buf_rdy_i low: no push, no token accepted, all counters hold (also in ZRUN).
//  - clr_i: highest priority; tok_rdy_o=0, buf_push_o=0, buf_vld_o=0 that cycle; next cycle
//    WAIT_BASE, counters 0, err_o=0. blk_cnt_o not cleared by clr_i.
//  - Async reset mid-block: everything returns to reset values immediately.
// CONFIGURATION
//  EBPC_BUF_CTRL_STATS_EN defined: blk_cnt_o increments (wrapping) on each buf_vld_o cycle.
//  Undefined: blk_cnt_o tied to 0, no counter flops. Port list identical in both builds.
// TESTING (DATA_W=8 -> 9 planes)
//  1 base 0x12 + 9 dbp tokens, buf_rdy_i=1 -> 10 pushes in 10 cycles, buf_vld_o only on 10th, err_o=0.
//  2 base, 2 dbp, zero-run data=6 (L=7) -> 7 zero pushes, tok_rdy_o low 6 cycles, buf_vld_o on last.
//  3 test 1 with buf_rdy_i 50% random -> no push while low, data order/count preserved, one buf_vld_o.
//  4 dbp token in WAIT_BASE -> dropped, err_o=1 next cycle and stays; then base+3 dbp+zero-run L=12
//    -> exactly 6 zero pushes, buf_vld_o on 6th.
//  5 clr_i during ZRUN (run_left=3) -> buf_clr_o=1, no push; next cycle WAIT_BASE, err_o=0, base accepted.
//  6 rst_ni low mid-DBP -> outputs at reset values; STATS build: blk_cnt_o=2 after two full blocks.

Source files
------------

// File: rtl/dbp_buffer_ctrl.sv
// Delta-bit-plane block buffer sequencer: expands zero runs, counts DATA_W+1 planes per block.
// Optional block statistics counter enabled by defining EBPC_BUF_CTRL_STATS_EN.
module dbp_buffer_ctrl #(
   parameter int DATA_W = 8,
   parameter int RUN_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] tok_data_i,
   input  logic [1:0]        tok_kind_i,
   input  logic              tok_vld_i,
   output logic              tok_rdy_o,
   output logic [DATA_W-1:0] buf_data_o,
   output logic              buf_push_o,
   output logic              buf_vld_o,
   input  logic              buf_rdy_i,
   output logic              buf_clr_o,
   output logic              err_o,
   output logic [31:0]       blk_cnt_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int LEN_W = ((RUN_W + 1) > (CNT_W + 1)) ? (RUN_W + 1) : (CNT_W + 1);

   localparam logic [1:0] WAIT_BASE = 2'd0;
   localparam logic [1:0] DBP       = 2'd1;
   localparam logic [1:0] ZRUN      = 2'd2;

   localparam logic [1:0] KIND_BASE = 2'b00;
   localparam logic [1:0] KIND_DBP  = 2'b01;
   localparam logic [1:0] KIND_ZRUN = 2'b10;

   localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(DATA_W);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] dbp_cnt_q, dbp_cnt_d;
   logic [CNT_W-1:0] run_left_q, run_left_d;
   logic             err_q, err_d;
   logic [LEN_W-1:0] run_len, planes_left, run_eff;
   logic             last_plane;

   // planes_left counts the plane pushed in the accepting cycle as well
   assign run_len     = LEN_W'(tok_data_i[RUN_W-1:0]) + LEN_W'(1);
   assign planes_left = LEN_W'(DATA_W + 1) - LEN_W'(dbp_cnt_q);
   assign run_eff     = (run_len > planes_left) ? planes_left : run_len;
   assign last_plane  = (dbp_cnt_q == LAST_PLANE);

   assign buf_clr_o = clr_i;
   assign err_o     = err_q;

   always_comb begin
      state_d    = state_q;
      dbp_cnt_d  = dbp_cnt_q;
      run_left_d = run_left_q;
      err_d      = err_q;
      tok_rdy_o  = 1'b0;
      buf_push_o = 1'b0;
      buf_data_o = '0;
      buf_vld_o  = 1'b0;
      if (clr_i) begin
         state_d    = WAIT_BASE;
         dbp_cnt_d  = '0;
         run_left_d = '0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            WAIT_BASE: begin
               tok_rdy_o = buf_rdy_i;
               if (tok_vld_i && buf_rdy_i) begin
                  if (tok_kind_i == KIND_BASE) begin
                     buf_push_o = 1'b1;
                     buf_data_o = tok_data_i;
                     dbp_cnt_d  = '0;
                     state_d    = DBP;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            DBP: begin
               tok_rdy_o = buf_rdy_i;
               if (tok_vld_i && buf_rdy_i) begin
                  case (tok_kind_i)
                     KIND_DBP: begin
                        buf_push_o = 1'b1;
                        buf_data_o = tok_data_i;
                        if (last_plane) begin
                           buf_vld_o = 1'b1;
                           dbp_cnt_d = '0;
                           state_d   = WAIT_BASE;
                        end else begin
                           dbp_cnt_d = dbp_cnt_q + CNT_W'(1);
                        end
                     end
                     KIND_ZRUN: begin
                        buf_push_o = 1'b1;
                        if (last_plane) begin
                           buf_vld_o = 1'b1;
                           dbp_cnt_d = '0;
                           state_d   = WAIT_BASE;
                        end else begin
                           dbp_cnt_d = dbp_cnt_q + CNT_W'(1);
                           if (run_eff > LEN_W'(1)) begin
                              run_left_d = CNT_W'(run_eff - LEN_W'(1));
                              state_d    = ZRUN;
                           end
                        end
                     end
                     default: err_d = 1'b1;
                  endcase
               end
            end
            ZRUN: begin
               if (buf_rdy_i) begin
                  buf_push_o = 1'b1;
                  run_left_d = run_left_q - CNT_W'(1);
                  if (last_plane) begin
                     buf_vld_o  = 1'b1;
                     dbp_cnt_d  = '0;
                     run_left_d = '0;
                     state_d    = WAIT_BASE;
                  end else begin
                     dbp_cnt_d = dbp_cnt_q + CNT_W'(1);
                     if (run_left_q == CNT_W'(1)) state_d = DBP;
                  end
               end
            end
            default: state_d = WAIT_BASE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= WAIT_BASE;
         dbp_cnt_q  <= '0;
         run_left_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dbp_cnt_q  <= dbp_cnt_d;
         run_left_q <= run_left_d;
         err_q      <= err_d;
      end
   end

`ifdef EBPC_BUF_CTRL_STATS_EN
   logic [31:0] blk_cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        blk_cnt_q <= '0;
      else if (buf_vld_o) blk_cnt_q <= blk_cnt_q + 32'd1;
   end
   assign blk_cnt_o = blk_cnt_q;
`else
   assign blk_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dbp_buffer_ctrl.sv
// Directed bench for dbp_buffer_ctrl (DATA_W=8 -> 9 dbp planes per block).
module tb_dbp_buffer_ctrl;

   localparam logic [1:0] K_BASE = 2'b00;
   localparam logic [1:0] K_DBP  = 2'b01;
   localparam logic [1:0] K_ZR   = 2'b10;
   localparam logic [1:0] K_RSV  = 2'b11;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clr_i;
   logic [7:0]  tok_data_i;
   logic [1:0]  tok_kind_i;
   logic        tok_vld_i;
   logic        tok_rdy_o;
   logic [7:0]  buf_data_o;
   logic        buf_push_o;
   logic        buf_vld_o;
   logic        buf_rdy_i;
   logic        buf_clr_o;
   logic        err_o;
   logic [31:0] blk_cnt_o;

   int checks = 0;
   int errors = 0;

   dbp_buffer_ctrl #(.DATA_W(8), .RUN_W(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
      .tok_data_i(tok_data_i), .tok_kind_i(tok_kind_i), .tok_vld_i(tok_vld_i),
      .tok_rdy_o(tok_rdy_o), .buf_data_o(buf_data_o), .buf_push_o(buf_push_o),
      .buf_vld_o(buf_vld_o), .buf_rdy_i(buf_rdy_i), .buf_clr_o(buf_clr_o),
      .err_o(err_o), .blk_cnt_o(blk_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       clr;
      logic       vld;
      logic [1:0] kind;
      logic [7:0] data;
      logic       e_rdy;
      logic       e_push;
      logic [7:0] e_data;
      logic       e_bvld;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tv(input logic c, input logic v, input logic [1:0] k, input logic [7:0] d,
                     input logic er, input logic ep, input logic [7:0] ed, input logic eb, input logic ee);
      vecs.push_back('{clr: c, vld: v, kind: k, data: d, e_rdy: er, e_push: ep,
                       e_data: ed, e_bvld: eb, e_err: ee});
   endtask

   task automatic drv(input logic c, input logic v, input logic [1:0] k, input logic [7:0] d, input logic b);
      clr_i = c; tok_vld_i = v; tok_kind_i = k; tok_data_i = d; buf_rdy_i = b;
   endtask

   // checks the combinational response at the falling edge, then advances one cycle
   task automatic step(input string nm, input logic er, input logic ep, input logic [7:0] ed,
                       input logic eb, input logic ee);
      @(negedge clk_i);
      chk({nm, "_rdy"}, tok_rdy_o, er);
      chk({nm, "_push"}, buf_push_o, ep);
      if (ep) chk({nm, "_data"}, buf_data_o, ed);
      chk({nm, "_bvld"}, buf_vld_o, eb);
      chk({nm, "_err"}, err_o, ee);
      chk({nm, "_clr"}, buf_clr_o, clr_i);
      @(posedge clk_i); #1;
   endtask

   logic [7:0] t3_exp [10];
   int         t3_idx;
   logic       t3_rdy;

   initial begin
      // test 1: base + 9 dbp, buffer always ready
      tv(0, 1, K_BASE, 8'h12, 1, 1, 8'h12, 0, 0);
      for (int i = 1; i <= 9; i++) tv(0, 1, K_DBP, 8'(i), 1, 1, 8'(i), (i == 9), 0);
      tv(0, 0, K_BASE, 8'h00, 1, 0, 8'h00, 0, 0);
      // test 2: base, 2 dbp, zero-run L=7
      tv(0, 1, K_BASE, 8'h34, 1, 1, 8'h34, 0, 0);
      tv(0, 1, K_DBP, 8'hA1, 1, 1, 8'hA1, 0, 0);
      tv(0, 1, K_DBP, 8'hA2, 1, 1, 8'hA2, 0, 0);
      tv(0, 1, K_ZR, 8'h06, 1, 1, 8'h00, 0, 0);
      for (int j = 1; j <= 6; j++) tv(0, 0, K_BASE, 8'h00, 0, 1, 8'h00, (j == 6), 0);
      tv(0, 0, K_BASE, 8'h00, 1, 0, 8'h00, 0, 0);
      // test 4: dbp in WAIT_BASE, then truncated zero-run L=12 -> 6 pushes
      tv(0, 1, K_DBP, 8'h77, 1, 0, 8'h00, 0, 0);
      tv(0, 1, K_BASE, 8'h40, 1, 1, 8'h40, 0, 1);
      for (int i = 1; i <= 3; i++) tv(0, 1, K_DBP, 8'(8'h40 + i), 1, 1, 8'(8'h40 + i), 0, 1);
      tv(0, 1, K_ZR, 8'h0B, 1, 1, 8'h00, 0, 1);
      for (int j = 1; j <= 5; j++) tv(0, 0, K_BASE, 8'h00, 0, 1, 8'h00, (j == 5), 1);
      tv(0, 0, K_BASE, 8'h00, 1, 0, 8'h00, 0, 1);
      tv(1, 0, K_BASE, 8'h00, 0, 0, 8'h00, 0, 1);
      tv(0, 0, K_BASE, 8'h00, 1, 0, 8'h00, 0, 0);
      // reserved kind, base in DBP (dropped, state kept), then clear
      tv(0, 1, K_RSV, 8'hFF, 1, 0, 8'h00, 0, 0);
      tv(0, 1, K_BASE, 8'h10, 1, 1, 8'h10, 0, 1);
      tv(0, 1, K_BASE, 8'h20, 1, 0, 8'h00, 0, 1);
      tv(0, 1, K_DBP, 8'h21, 1, 1, 8'h21, 0, 1);
      tv(1, 1, K_DBP, 8'h22, 0, 0, 8'h00, 0, 1);
      tv(0, 0, K_BASE, 8'h00, 1, 0, 8'h00, 0, 0);

      drv(0, 0, K_BASE, 8'h00, 1);
      rst_ni = 1'b0;
      #12;
      chk("rst_rdy", tok_rdy_o, 1);
      chk("rst_push", buf_push_o, 0);
      chk("rst_bvld", buf_vld_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_blk", blk_cnt_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drv(vecs[i].clr, vecs[i].vld, vecs[i].kind, vecs[i].data, 1'b1);
         step($sformatf("tbl%0d", i), vecs[i].e_rdy, vecs[i].e_push, vecs[i].e_data,
              vecs[i].e_bvld, vecs[i].e_err);
      end

      // test 3: test 1 with random buffer backpressure
      t3_exp[0] = 8'h12;
      for (int i = 1; i < 10; i++) t3_exp[i] = 8'(8'h80 + i);
      t3_idx = 0;
      for (int c = 0; c < 200 && t3_idx < 10; c++) begin
         t3_rdy = 1'($urandom_range(0, 1));
         drv(0, 1, (t3_idx == 0) ? K_BASE : K_DBP, t3_exp[t3_idx], t3_rdy);
         @(negedge clk_i);
         chk($sformatf("t3_c%0d_push", c), buf_push_o, t3_rdy);
         chk($sformatf("t3_c%0d_rdy", c), tok_rdy_o, t3_rdy);
         if (t3_rdy) chk($sformatf("t3_c%0d_data", c), buf_data_o, t3_exp[t3_idx]);
         chk($sformatf("t3_c%0d_bvld", c), buf_vld_o, t3_rdy && (t3_idx == 9));
         @(posedge clk_i); #1;
         if (t3_rdy) t3_idx++;
      end
      chk("t3_done", t3_idx, 10);
      drv(0, 0, K_BASE, 8'h00, 1);
      step("t3_idle", 1, 0, 8'h00, 0, 0);

      // test 5: clear during ZRUN with run_left=3
      drv(0, 1, K_RSV, 8'hFF, 1); step("t5a", 1, 0, 8'h00, 0, 0);
      drv(0, 1, K_BASE, 8'h66, 1); step("t5b", 1, 1, 8'h66, 0, 1);
      drv(0, 1, K_DBP, 8'h67, 1);  step("t5c", 1, 1, 8'h67, 0, 1);
      drv(0, 1, K_ZR, 8'h04, 1);   step("t5d", 1, 1, 8'h00, 0, 1);
      drv(0, 0, K_BASE, 8'h00, 0); step("t5e", 0, 0, 8'h00, 0, 1);
      drv(0, 0, K_BASE, 8'h00, 1); step("t5f", 0, 1, 8'h00, 0, 1);
      drv(1, 1, K_DBP, 8'h68, 1);  step("t5g", 0, 0, 8'h00, 0, 1);
      drv(0, 1, K_BASE, 8'h70, 1); step("t5h", 1, 1, 8'h70, 0, 0);

      // test 6: async reset mid-DBP with err_o set
      drv(0, 1, K_DBP, 8'h71, 1);  step("t6a", 1, 1, 8'h71, 0, 0);
      drv(0, 1, K_BASE, 8'h72, 1); step("t6b", 1, 0, 8'h00, 0, 0);
      drv(0, 1, K_DBP, 8'h73, 1);  step("t6c", 1, 1, 8'h73, 0, 1);
      drv(0, 1, K_DBP, 8'h74, 1);
      @(negedge clk_i);
      chk("t6_pre_push", buf_push_o, 1);
      chk("t6_pre_err", err_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_rst_push", buf_push_o, 0);
      chk("t6_rst_bvld", buf_vld_o, 0);
      chk("t6_rst_err", err_o, 0);
      chk("t6_rst_blk", blk_cnt_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int b = 0; b < 2; b++) begin
         drv(0, 1, K_BASE, 8'hB0, 1);
         step($sformatf("t6_b%0d_base", b), 1, 1, 8'hB0, 0, 0);
         for (int i = 1; i <= 9; i++) begin
            drv(0, 1, K_DBP, 8'(8'hC0 + i), 1);
            step($sformatf("t6_b%0d_d%0d", b, i), 1, 1, 8'(8'hC0 + i), (i == 9), 0);
         end
      end
      drv(0, 0, K_BASE, 8'h00, 1);
`ifdef EBPC_BUF_CTRL_STATS_EN
      chk("t6_blk_cnt", blk_cnt_o, 2);
`else
      chk("t6_blk_cnt", blk_cnt_o, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
